calc_gravity_ctrl: RTL
======================

// Module: calc_gravity_ctrl
// PURPOSE
//  Frame sequencer for the centre-of-gravity adders. Tracks pixel X/Y from sensor timing, applies ROI
//  and dark-pupil threshold, and drives three accumulators (weight, weight*X, weight*Y). It clears them
//  at frame start and captures their sums at frame end. Results go out on a valid/ready port to the divider.
// PARAMETERS
//  DATA_WIDTH    8   pixel / weight width
//  FACTOR_WIDTH  10  X/Y coordinate width (max 1023)
//  SUM_WIDTH     32  accumulator and result width
// PORTS
//  CCLK        in   1    clock
//  RST_N       in   1    asynchronous reset, active low
//  iENABLE     in   1    1 = run; 0 = idle and abort current frame
//  iVSYNC      in   1    frame sync, active high; rising edge = frame boundary
//  iDE         in   1    pixel valid (high across active line)
//  iDATA       in   DW   pixel value
//  iTHRESH     in   DW   pupil threshold
//  iROI_X0/X1  in   FW   ROI column bounds, inclusive
//  iROI_Y0/Y1  in   FW   ROI row bounds, inclusive
//  oACC_CLR    out  1    one-cycle accumulator clear
//  oACC_DE     out  1    accumulator enable
//  oACC_DATA   out  DW   weight to accumulators
//  oFACT_X     out  FW   X factor
//  oFACT_Y     out  FW   Y factor
//  iSUM_W/X/Y  in   SW   accumulator outputs (registered, 1-cycle latency)
//  oRES_VALID  out  1    result available
//  iRES_READY  in   1    downstream accepts result
//  oRES_W/X/Y  out  SW   captured sums
//  oOVERRUN    out  1    sticky: unread result overwritten
//  oBUSY       out  1    state != IDLE
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0, ROI regs 0.
//  Counters: x += 1 per iDE cycle and returns to 0 on iDE falling edge. y += 1 on each iDE falling edge.
//   Both clear on iVSYNC rising edge. Both saturate at 2^FW-1.
//  ROI regs latch on iVSYNC rising edge only, so mid-frame changes take effect next frame.
//  Weight = (iDATA < iTHRESH) ? iTHRESH - iDATA : 0.
//  Pixel qualifies if state ACCUM, iDE, and X0<=x<=X1, Y0<=y<=Y1.
//  Pipeline: oACC_DE/oACC_DATA/oFACT_X/oFACT_Y are registered, 1 cycle after the input pixel.
//   oACC_DE = 0 for non-qualifying pixels; data/factor outputs then hold their previous values.
//  FSM:
//   IDLE  : iENABLE=1 -> WAIT.
//   WAIT  : iVSYNC rise -> pulse oACC_CLR, -> ACCUM.
//   ACCUM : iVSYNC rise -> DRAIN.
//   DRAIN : 2 cycles, oACC_DE forced 0 (lets last pixel land in sums) -> CAPT.
//   CAPT  : 1 cycle. Load oRES_* from iSUM_*, set oRES_VALID, pulse oACC_CLR -> ACCUM.
//  iENABLE=0 in any state: IDLE next cycle, oACC_DE=0, partial frame discarded, no capture.
//   Any pending oRES_VALID/oRES_* is kept until accepted.
//  Handshake: oRES_VALID holds, with oRES_* stable, until a cycle with iRES_READY=1.
//   CAPT with VALID=1 and READY=0: overwrite with new result, set oOVERRUN.
//   CAPT with READY=1 in the same cycle: old accepted, new loaded, VALID stays 1, no overrun.
//  oOVERRUN clears only on reset or iENABLE=0.
//  A frame with zero weight still produces a result (W=0); the divider handles it.
//  Sensor timing guarantees iDE=0 for >=3 cycles after iVSYNC rise.
//   Any iDE in DRAIN/CAPT is dropped, not accumulated.
//  Widths: weight*FW product is guaranteed < 2^SW by choice of SW; no saturation is done here.
// TESTING
//  T1 4x4 frame, full ROI, THRESH=0x80, only pixel (2,1)=0x10, others 0xFF.
//     -> VALID after 2nd vsync, W=0x70, X=0xE0, Y=0x70.
//  T2 Two frames, READY held 0 -> OVERRUN=1, oRES_* = frame-2 values, VALID=1.
//  T3 READY=1 in the CAPT cycle of frame 2 -> frame-1 result consumed, frame-2 loaded, OVERRUN=0.
//  T4 ROI X0=X1=3, Y0=Y1=3, pixels (2,1)=0x10 and (3,3)=0x00, THRESH=0x80 -> W=0x80, X=0x180, Y=0x180.
//  T5 iENABLE drop mid-ACCUM, then RST_N pulse mid-frame -> IDLE, oACC_DE=0, no VALID.
//     After reset all outputs are 0; re-enable starts counting at the next vsync.
//  T6 THRESH=0 -> every weight 0, oACC_DE never 1, result W=X=Y=0 with VALID=1.

Source files
------------

// File: rtl/calc_gravity_ctrl.sv
// calc_gravity_ctrl: frame sequencer for the centre-of-gravity accumulators.
//   Tracks pixel X/Y from sensor timing, applies the ROI and the dark-pupil threshold,
//   and drives three external accumulators (weight, weight*X, weight*Y). The accumulators
//   are cleared at frame start and their sums are captured at frame end, then offered
//   to the divider on a valid/ready port.
// Ports:
//   CCLK, RST_N                 clock, asynchronous active-low reset
//   iENABLE                     1 = run, 0 = go idle and discard the current frame
//   iVSYNC, iDE, iDATA          sensor timing and pixel value
//   iTHRESH                     pupil threshold (weight = iTHRESH - iDATA when darker)
//   iROI_X0/X1/Y0/Y1            inclusive ROI bounds, latched at each frame boundary
//   oACC_CLR/DE/DATA, oFACT_X/Y accumulator control, weight and coordinate factors
//   iSUM_W/X/Y                  accumulator sums (registered, 1-cycle latency)
//   oRES_VALID, iRES_READY      result handshake
//   oRES_W/X/Y                  captured sums
//   oOVERRUN                    sticky flag: an unread result was overwritten
//   oBUSY                       sequencer is not idle
module calc_gravity_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int FACTOR_WIDTH = 10,
  parameter int SUM_WIDTH    = 32
) (
  input  logic                    CCLK,
  input  logic                    RST_N,
  input  logic                    iENABLE,
  input  logic                    iVSYNC,
  input  logic                    iDE,
  input  logic [DATA_WIDTH-1:0]   iDATA,
  input  logic [DATA_WIDTH-1:0]   iTHRESH,
  input  logic [FACTOR_WIDTH-1:0] iROI_X0,
  input  logic [FACTOR_WIDTH-1:0] iROI_X1,
  input  logic [FACTOR_WIDTH-1:0] iROI_Y0,
  input  logic [FACTOR_WIDTH-1:0] iROI_Y1,
  output logic                    oACC_CLR,
  output logic                    oACC_DE,
  output logic [DATA_WIDTH-1:0]   oACC_DATA,
  output logic [FACTOR_WIDTH-1:0] oFACT_X,
  output logic [FACTOR_WIDTH-1:0] oFACT_Y,
  input  logic [SUM_WIDTH-1:0]    iSUM_W,
  input  logic [SUM_WIDTH-1:0]    iSUM_X,
  input  logic [SUM_WIDTH-1:0]    iSUM_Y,
  output logic                    oRES_VALID,
  input  logic                    iRES_READY,
  output logic [SUM_WIDTH-1:0]    oRES_W,
  output logic [SUM_WIDTH-1:0]    oRES_X,
  output logic [SUM_WIDTH-1:0]    oRES_Y,
  output logic                    oOVERRUN,
  output logic                    oBUSY
);
  localparam int DW = DATA_WIDTH;
  localparam int FW = FACTOR_WIDTH;
  localparam int SW = SUM_WIDTH;

  typedef enum logic [2:0] {IDLE, WAIT, ACCUM, DRAIN, CAPT} state_t;

  state_t          state_q, state_d;
  logic            drn_q, drn_d;
  logic            vsync_q, de_q;
  logic [FW-1:0]   x_q, x_d, y_q, y_d;
  logic [FW-1:0]   roi_x0_q, roi_x1_q, roi_y0_q, roi_y1_q;
  logic [FW-1:0]   roi_x0_d, roi_x1_d, roi_y0_d, roi_y1_d;
  logic            acc_clr_q, acc_clr_d;
  logic            acc_de_q, acc_de_d;
  logic [DW-1:0]   acc_data_q, acc_data_d;
  logic [FW-1:0]   fact_x_q, fact_x_d, fact_y_q, fact_y_d;
  logic            res_valid_q, res_valid_d;
  logic [SW-1:0]   res_w_q, res_w_d, res_x_q, res_x_d, res_y_q, res_y_d;
  logic            overrun_q, overrun_d;

  logic            vs_rise, de_fall, in_roi, qual, capture;
  logic [DW-1:0]   wgt;

  assign vs_rise = iVSYNC & ~vsync_q;
  assign de_fall = ~iDE & de_q;

  // Coordinates: x is the column of the pixel presented this cycle, y the current line.
  always_comb begin
    x_d = vs_rise ? '0 : iDE ? (&x_q ? x_q : x_q + 1'b1) : de_fall ? '0 : x_q;
    y_d = vs_rise ? '0 : (de_fall && !(&y_q)) ? y_q + 1'b1 : y_q;
    roi_x0_d = vs_rise ? iROI_X0 : roi_x0_q;
    roi_x1_d = vs_rise ? iROI_X1 : roi_x1_q;
    roi_y0_d = vs_rise ? iROI_Y0 : roi_y0_q;
    roi_y1_d = vs_rise ? iROI_Y1 : roi_y1_q;
  end

  // Zero-weight pixels contribute nothing, so they are not presented to the accumulators.
  assign wgt    = (iDATA < iTHRESH) ? iTHRESH - iDATA : '0;
  assign in_roi = (x_q >= roi_x0_q) && (x_q <= roi_x1_q) && (y_q >= roi_y0_q) && (y_q <= roi_y1_q);
  assign qual   = iENABLE && (state_q == ACCUM) && iDE && in_roi && (wgt != '0);

  always_comb begin
    acc_de_d   = qual;
    acc_data_d = qual ? wgt : acc_data_q;
    fact_x_d   = qual ? x_q : fact_x_q;
    fact_y_d   = qual ? y_q : fact_y_q;
  end

  // Sequencer. The frame-ending vsync also opens the next frame: the two DRAIN cycles let
  // the last pixel settle in the sums, CAPT samples them and clears the accumulators.
  always_comb begin
    state_d   = state_q;
    drn_d     = drn_q;
    acc_clr_d = 1'b0;
    if (!iENABLE) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = WAIT;
        WAIT:    if (vs_rise) begin
                   state_d   = ACCUM;
                   acc_clr_d = 1'b1;
                 end
        ACCUM:   if (vs_rise) begin
                   state_d = DRAIN;
                   drn_d   = 1'b0;
                 end
        DRAIN:   begin
                   drn_d   = 1'b1;
                   state_d = drn_q ? CAPT : DRAIN;
                 end
        CAPT:    begin
                   state_d   = ACCUM;
                   acc_clr_d = 1'b1;
                 end
        default: state_d = IDLE;
      endcase
    end
  end

  // Result port: a capture always wins; an unaccepted old result becomes an overrun.
  assign capture = iENABLE && (state_q == CAPT);

  always_comb begin
    res_valid_d = capture | (res_valid_q & ~iRES_READY);
    res_w_d     = capture ? iSUM_W : res_w_q;
    res_x_d     = capture ? iSUM_X : res_x_q;
    res_y_d     = capture ? iSUM_Y : res_y_q;
    overrun_d   = iENABLE & (overrun_q | (capture & res_valid_q & ~iRES_READY));
  end

  always_ff @(posedge CCLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      drn_q       <= 1'b0;
      vsync_q     <= 1'b0;
      de_q        <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      roi_x0_q    <= '0;
      roi_x1_q    <= '0;
      roi_y0_q    <= '0;
      roi_y1_q    <= '0;
      acc_clr_q   <= 1'b0;
      acc_de_q    <= 1'b0;
      acc_data_q  <= '0;
      fact_x_q    <= '0;
      fact_y_q    <= '0;
      res_valid_q <= 1'b0;
      res_w_q     <= '0;
      res_x_q     <= '0;
      res_y_q     <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      drn_q       <= drn_d;
      vsync_q     <= iVSYNC;
      de_q        <= iDE;
      x_q         <= x_d;
      y_q         <= y_d;
      roi_x0_q    <= roi_x0_d;
      roi_x1_q    <= roi_x1_d;
      roi_y0_q    <= roi_y0_d;
      roi_y1_q    <= roi_y1_d;
      acc_clr_q   <= acc_clr_d;
      acc_de_q    <= acc_de_d;
      acc_data_q  <= acc_data_d;
      fact_x_q    <= fact_x_d;
      fact_y_q    <= fact_y_d;
      res_valid_q <= res_valid_d;
      res_w_q     <= res_w_d;
      res_x_q     <= res_x_d;
      res_y_q     <= res_y_d;
      overrun_q   <= overrun_d;
    end
  end

  assign oACC_CLR   = acc_clr_q;
  assign oACC_DE    = acc_de_q;
  assign oACC_DATA  = acc_data_q;
  assign oFACT_X    = fact_x_q;
  assign oFACT_Y    = fact_y_q;
  assign oRES_VALID = res_valid_q;
  assign oRES_W     = res_w_q;
  assign oRES_X     = res_x_q;
  assign oRES_Y     = res_y_q;
  assign oOVERRUN   = overrun_q;
  assign oBUSY      = (state_q != IDLE);
endmodule
